// File: rtl/asip_pkg.sv
// asip_pkg: shared ASIP types and constants for the execute-stage units
package asip_pkg;
    localparam int MODMUL_N = 32;
    localparam int MODMUL_LATENCY = MODMUL_N + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} modmul_state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_MODMUL
    } alu_sel_t;
endpackage

// File: rtl/mod_mul_unit_if.sv
// mod_mul_unit_if: operand/result and pipeline-control bundle of the modular multiplier
interface mod_mul_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic         flush;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] modulus;
    logic         busy;
    logic         stall;
    logic         done;
    logic         err;
    logic [N-1:0] result;
    modport master (
        output start, flush, op_a, op_b, modulus,
        input  busy, stall, done, err, result
    );
    modport slave (
        input  start, flush, op_a, op_b, modulus,
        output busy, stall, done, err, result
    );
endinterface

// File: rtl/mod_mul_step.sv
// mod_mul_step: one Blakley iteration, r_o = (2*r_i + (bit_i ? b_i : 0)) mod n_i, given r_i < n_i
module mod_mul_step #(
    parameter int N = 32
) (
    input  logic [N+1:0] r_i,
    input  logic         bit_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] n_i,
    output logic [N+1:0] r_o
);
    logic [N+1:0] n_w, sum, sub1;
    assign n_w  = {2'b00, n_i};
    // 2R + b < 3n, so two conditional subtractions restore R < n
    assign sum  = (r_i << 1) + (bit_i ? {2'b00, b_i} : '0);
    assign sub1 = sum >= n_w ? sum - n_w : sum;
    assign r_o  = sub1 >= n_w ? sub1 - n_w : sub1;
endmodule

// File: rtl/mod_mul_unit.sv
// mod_mul_unit: multi-cycle (a*b) mod n, MSB-first interleaved shift-add, stalls the pipe until done
module mod_mul_unit import asip_pkg::*; #(
    parameter int N = MODMUL_N
) (
    input logic           clock,
    input logic           reset,
    mod_mul_unit_if.slave bus
);
    localparam int CW = $clog2(N);
    modmul_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, n_q, n_d, result_q, result_d;
    logic [N+1:0]  r_q, r_d, step_r;
    logic          err_q, err_d, range_err;
    mod_mul_step #(.N(N)) u_step (
        .r_i   (r_q),
        .bit_i (a_q[cnt_q]),
        .b_i   (b_q),
        .n_i   (n_q),
        .r_o   (step_r)
    );
    assign range_err = bus.modulus == '0 || bus.op_a >= bus.modulus || bus.op_b >= bus.modulus;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        err_d    = err_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    n_d     = bus.modulus;
                    r_d     = '0;
                    cnt_d   = CW'(N - 1);
                    err_d   = range_err;
                    state_d = range_err ? DONE : CALC;
                    if (range_err) result_d = '0;
                end
                CALC: begin
                    r_d   = step_r;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_d = step_r[N-1:0];
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end
    assign bus.busy   = state_q == CALC;
    assign bus.done   = state_q == DONE;
    assign bus.err    = state_q == DONE && err_q;
    assign bus.stall  = (state_q == IDLE && bus.start && !bus.flush) || state_q == CALC;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mod_mul_unit.sv
// tb_mod_mul_unit: scoreboard bench for mod_mul_unit with a 64-bit reference model
module tb_mod_mul_unit;
    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;
    logic clock, reset;
    int checks, errors;
    logic [31:0] last_res;
    exp_t exp_q[$];
    mod_mul_unit_if #(.N(32)) bus ();
    mod_mul_unit #(.N(32)) dut (.clock(clock), .reset(reset), .bus(bus));
    initial clock = 0;
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clock) begin
        if (bus.err && !bus.done) chk("err_without_done", bus.err, 0);
        if (bus.done) begin
            if (exp_q.size() == 0) chk("unexpected_done", bus.done, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", bus.result, e.res);
                chk("err", bus.err, e.err);
            end
        end
    end
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n, input bit hold);
        int k, busy_n;
        logic e;
        logic [31:0] r;
        e = (n == 0) || (a >= n) || (b >= n);
        r = e ? 32'd0 : 32'((64'(a) * 64'(b)) % 64'(n));
        exp_q.push_back('{r, e});
        bus.op_a = a;
        bus.op_b = b;
        bus.modulus = n;
        bus.start = 1;
        #1;
        chk("stall_accept", bus.stall, 1);
        step();
        if (!hold) bus.start = 0;
        k = 0;
        busy_n = 0;
        while (!bus.done && k < 100) begin
            busy_n += int'(bus.busy);
            if (hold) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
                bus.modulus = $urandom;
            end
            step();
            k++;
        end
        bus.start = 0;
        chk("latency", k, e ? 0 : 32);
        chk("busy_cycles", busy_n, e ? 0 : 32);
        chk("stall_at_done", bus.stall, 0);
        step();
        chk("result_hold", bus.result, r);
        chk("idle_after_done", bus.done, 0);
        last_res = r;
    endtask
    initial begin
        checks = 0;
        errors = 0;
        bus.start = 0;
        bus.flush = 0;
        bus.op_a = 0;
        bus.op_b = 0;
        bus.modulus = 0;
        reset = 1;
        repeat (2) step();
        reset = 0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_result", bus.result, 0);
        run_op(7, 9, 11, 0);
        run_op(2790, 2790, 3233, 0);
        chk("rsa_toy", last_res, 32'd2269);
        run_op(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 0);
        run_op(12, 3, 11, 0);
        run_op(5, 3, 0, 0);
        run_op(3, 11, 11, 0);
        run_op(7, 9, 11, 1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] n;
            n = $urandom | 32'h1;
            run_op($urandom % n, $urandom % n, n, 0);
        end
        bus.op_a = 2790;
        bus.op_b = 2790;
        bus.modulus = 3233;
        bus.start = 1;
        step();
        bus.start = 0;
        repeat (10) step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_stall", bus.stall, 0);
        chk("flush_done", bus.done, 0);
        chk("flush_result", bus.result, last_res);
        repeat (40) step();
        bus.start = 1;
        bus.flush = 1;
        #1;
        chk("flush_prio_stall", bus.stall, 0);
        step();
        bus.start = 0;
        bus.flush = 0;
        chk("flush_prio_busy", bus.busy, 0);
        repeat (3) step();
        bus.op_a = 7;
        bus.op_b = 9;
        bus.modulus = 11;
        bus.start = 1;
        step();
        bus.start = 0;
        repeat (5) step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_stall", bus.stall, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_err", bus.err, 0);
        chk("rst_mid_result", bus.result, 0);
        run_op(7, 9, 11, 0);
        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_mul_unit.md
Name: mod_mul_unit

Overview:
- Multi-cycle modular multiplier in the execute stage of the RSA decryption ASIP. Computes (a*b) mod n with an interleaved shift-add (Blakley) algorithm.
- Result is muxed into alu_result_ex and registered by the EX/MEM pipeline register.
- Asserts a stall so the IF, ID and ID/EX registers hold, and EX/MEM receives a bubble, until the result is ready.

Parameters:
N, 32, operand, modulus and result width in bits

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  decoded modmul instruction present in EX
- flush  in  1  pipeline flush from the hazard unit; aborts the operation
- op_a  in  N  multiplier a (rda_ex)
- op_b  in  N  multiplicand b (rdb_ex)
- modulus  in  N  modulus n
- busy  out  1  iteration in progress
- stall  out  1  combinational freeze request to the hazard unit
- done  out  1  one-cycle pulse: result valid
- err  out  1  one-cycle pulse with done: operand range violation
- result  out  N  (a*b) mod n; held until the next accepted start

Behaviour:
- States: IDLE, CALC, DONE. Reset value of every output is 0; state resets to IDLE.
- IDLE, start=1, flush=0 at a rising edge: accept the operation.
  - Capture a, b, n.
  - Clear accumulator R (N+2 bits).
  - Load step counter to N-1.
- Range check at acceptance: n==0, a>=n or b>=n.
  - Go directly to DONE with err_r=1 and result=0.
  - No iteration is performed; done is seen one cycle after acceptance.
- Otherwise go to CALC with busy=1.
- Each CALC edge processes bit i of a, MSB first (i = counter):
  - R' = 2R + (a[i] ? b : 0).
  - If R' >= n, subtract n.
  - If the result is still >= n, subtract n again.
  - Invariant: R < n before and after each step. Intermediate values fit in N+2 bits, unsigned.
- CALC with counter==0: perform the last step, write R[N-1:0] to result, go to DONE.
- DONE: done=1 (err=1 on the error path) for exactly one cycle, then IDLE. The result register is unchanged.
- Latency: acceptance at edge 0; steps at edges 1..N; done is high during the cycle between edges N and N+1.
- stall = (state==IDLE && start && !flush) || state==CALC.
  - stall is low in DONE, so the instruction advances into EX/MEM with the result in the same cycle done is high.
- start while in CALC or DONE: ignored; no re-capture.
- flush in any state: next state IDLE.
  - busy, done and err are cleared; result is unchanged; no done pulse.
  - flush has priority over start.
- reset mid-operation: IDLE next cycle, all outputs 0, including result.
- The modulus input is sampled only at acceptance; changes during CALC have no effect.

Decomposition:
- Shared package asip_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} modmul_state_t.
  - Constant MODMUL_LATENCY = N+1.
  - ALU-select encoding for the modmul opcode, used by the EX result mux.
- Sub-module mod_mul_step: purely combinational single iteration (R, bit, b, n -> R'). This allows formal or exhaustive checking at small N.
- mod_mul_unit holds the FSM, counter and registers.

Test Plan:
- Small case: N=32, a=7, b=9, n=11, start pulse -> stall high for 33 cycles, then done=1, err=0, result=8 exactly at cycle 33 after acceptance; result holds 8 afterwards.
- RSA toy: a=b=2790, n=3233 -> result=2269 (0x8DD). busy high for exactly 32 cycles.
- Width boundary: n=0xFFFFFFFB, a=b=0xFFFFFFFA -> result=1, no overflow.
- Range errors: a=12, n=11 -> done and err high together one cycle after acceptance, result=0, busy never asserted. Repeat with n=0 -> same response.
- Abort and ignore:
  - Start held high through CALC with changing operands -> only the first operands are used (7, 9, 11 gives 8).
  - flush at step 10 -> IDLE next cycle, no done, stall low, result keeps its previous value.
- Reset mid-CALC at step 5 -> next cycle all outputs 0. A new start then completes normally (7, 9, 11 gives 8).
